// File: rtl/bcd_input_converter.sv
// Sequential packed-BCD to binary converter: one multiply-by-10-and-add per digit, MSD first.
// Optional define BCD_INPUT_SYNC_EN adds a 2-flop synchronizer and rising-edge detector on start.
module bcd_input_converter #(
    parameter int DIGITS = 8,
    parameter int WIDTH  = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcd,
    output logic [WIDTH-1:0]      binary,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);
    localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {IDLE, CONVERT, DONE} state_t;

    state_t                state, state_next;
    logic [4*DIGITS-1:0]   shreg;
    logic [WIDTH-1:0]      acc;
    logic [CW-1:0]         count;
    logic                  err_flag;
    logic                  go;
    logic                  last_step;
    logic [WIDTH-1:0]      acc_step;

    function automatic logic any_bad_nibble(input logic [4*DIGITS-1:0] v);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) bad = 1'b1;
        end
        return bad;
    endfunction

    function automatic logic [WIDTH-1:0] mul10_add(input logic [WIDTH-1:0] a,
                                                   input logic [3:0] nib);
        return (a << 3) + (a << 1) + {{(WIDTH-4){1'b0}}, nib};
    endfunction

`ifdef BCD_INPUT_SYNC_EN
    logic sync1, sync2, sync_prev;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1     <= 1'b0;
            sync2     <= 1'b0;
            sync_prev <= 1'b0;
        end else begin
            sync1     <= start;
            sync2     <= sync1;
            sync_prev <= sync2;
        end
    end

    assign go = sync2 & ~sync_prev;
`else
    assign go = start;
`endif

    assign last_step = (count == CW'(DIGITS - 1));
    assign acc_step  = mul10_add(acc, shreg[4*DIGITS-1 -: 4]);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (go) state_next = CONVERT;
            CONVERT: if (last_step) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy  = (state != IDLE);
        done  = (state == DONE);
        error = (state == DONE) && err_flag;
    end

    // binary is loaded on the final step so it is valid in the same cycle as done
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            shreg    <= '0;
            acc      <= '0;
            count    <= '0;
            err_flag <= 1'b0;
            binary   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (go) begin
                        shreg    <= bcd;
                        acc      <= '0;
                        count    <= '0;
                        err_flag <= any_bad_nibble(bcd);
                    end
                end
                CONVERT: begin
                    acc   <= acc_step;
                    shreg <= shreg << 4;
                    count <= count + CW'(1);
                    if (last_step && !err_flag) binary <= acc_step;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_bcd_input_converter.sv
// Directed-vector bench for bcd_input_converter (DIGITS=8, WIDTH=32).
module tb_bcd_input_converter;
    logic        clock;
    logic        reset;
    logic        start;
    logic [31:0] bcd;
    logic [31:0] binary;
    logic        busy;
    logic        done;
    logic        error;

    int total = 0;
    int bad   = 0;

`ifdef BCD_INPUT_SYNC_EN
    localparam int LAT = 11;
`else
    localparam int LAT = 9;
`endif

    bcd_input_converter #(.DIGITS(8), .WIDTH(32)) dut (
        .clock  (clock),
        .reset  (reset),
        .start  (start),
        .bcd    (bcd),
        .binary (binary),
        .busy   (busy),
        .done   (done),
        .error  (error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // one-cycle start pulse, then wait (bounded) for done and check the result
    task automatic run_conv(input string tag, input logic [31:0] val,
                            input logic [31:0] exp_bin, input logic exp_err);
        int cyc;
        int busy_cnt;
        bcd   = val;
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 1;
        busy_cnt = busy ? 1 : 0;
        while (!done && cyc < 50) begin
            tick();
            cyc++;
            if (busy) busy_cnt++;
        end
        chk({tag, "_done"}, {31'b0, done}, 32'd1);
        chk({tag, "_lat"}, cyc, LAT);
        chk({tag, "_busy"}, busy_cnt, 9);
        chk({tag, "_bin"}, binary, exp_bin);
        chk({tag, "_err"}, {31'b0, error}, {31'b0, exp_err});
        tick();
        chk({tag, "_done_clr"}, {30'b0, done, error}, 32'd0);
        chk({tag, "_idle"}, {31'b0, busy}, 32'd0);
    endtask

    initial begin
        int dones;
        int first_done;
        int second_done;

        reset = 1'b1;
        start = 1'b0;
        bcd   = 32'h0;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_out", {binary[27:0], busy, done, error, 1'b0}, 32'd0);
        reset = 1'b0;
        tick();

        // basic and boundary values
        run_conv("t1_123", 32'h00000123, 32'h0000007B, 1'b0);
        run_conv("t2_max", 32'h99999999, 32'h05F5E0FF, 1'b0);
        run_conv("t2_zero", 32'h00000000, 32'h00000000, 1'b0);
        run_conv("t_mix", 32'h12345678, 32'd12345678, 1'b0);

        // illegal nibble keeps the previous result
        run_conv("t3_pre", 32'h00000123, 32'd123, 1'b0);
        run_conv("t3_bad", 32'h00A00001, 32'd123, 1'b1);

        // re-pulsed start and bcd changes mid-conversion are ignored
        bcd   = 32'h00000456;
        start = 1'b1;
        tick();
        start = 1'b0;
        dones = 0;
        for (int c = 1; c <= 25; c++) begin
            if (done) begin
                dones++;
                chk("t4_bin", binary, 32'd456);
            end
            start = (c == 3 || c == 5);
            if (c == 4) bcd = 32'h00000999;
            tick();
        end
        start = 1'b0;
        chk("t4_ndone", dones, 1);

        // asynchronous reset mid-conversion
        bcd   = 32'h00000777;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        chk("t5_busy_pre", {31'b0, busy}, 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("t5_rst_out", {binary[28:0], busy, done, error}, 32'd0);
        tick();
        reset = 1'b0;
        dones = 0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (done) dones++;
        end
        chk("t5_nodone", dones, 0);
        run_conv("t5_after", 32'h00000789, 32'd789, 1'b0);

        // start held high
        bcd   = 32'h00000042;
        start = 1'b1;
        dones = 0;
        first_done = 0;
        second_done = 0;
        for (int c = 1; c <= 30; c++) begin
            tick();
            if (done) begin
                dones++;
                if (dones == 1) first_done = c;
                if (dones == 2) second_done = c;
                chk("held_bin", binary, 32'd42);
            end
        end
        start = 1'b0;
`ifdef BCD_INPUT_SYNC_EN
        chk("t6_ndone", dones, 1);
        chk("t6_when", first_done, 11);
`else
        chk("held_ndone", dones, 3);
        chk("held_first", first_done, 9);
        chk("held_period", second_done - first_done, 10);
`endif
        repeat (15) tick();
        chk("final_idle", {31'b0, busy}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
